demux_1_4_dispatcher: RTL

DEMUX_1_4_DISPATCHER -- requirements
Module: demux_1_4_dispatcher

---
 rtl/demux_1_4_dispatcher_pkg.sv | 14 +
 rtl/demux_1_4_n_bit.sv | 28 ++
 rtl/demux_1_4_dispatcher.sv | 109 ++++++++++
 3 files changed

// File: rtl/demux_1_4_dispatcher_pkg.sv
// Shared encodings for the 1-to-4 dispatcher: FSM states, dispatch modes, channel count.
package demux_1_4_dispatcher_pkg;

  localparam int unsigned NCH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

endpackage

// File: rtl/demux_1_4_n_bit.sv
// N-bit 1-to-4 demultiplexer: i0 is routed to out<{s1,s0}>, all other outputs are zero.
module demux_1_4_n_bit #(
  parameter int unsigned N = 4
) (
  input  logic         s0,
  input  logic         s1,
  input  logic [N-1:0] i0,
  output logic [N-1:0] out0,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic [N-1:0] out3
);

  always_comb begin
    out0 = '0;
    out1 = '0;
    out2 = '0;
    out3 = '0;
    unique case ({s1, s0})
      2'd0: out0 = i0;
      2'd1: out1 = i0;
      2'd2: out2 = i0;
      2'd3: out3 = i0;
      default: ;
    endcase
  end

endmodule

// File: rtl/demux_1_4_dispatcher.sv
// Single-entry holding register dispatching words to one of four channels,
// round-robin or directed, with per-channel delivery counters.
module demux_1_4_dispatcher
  import demux_1_4_dispatcher_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    in_dest,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [N-1:0]  out0,
  output logic [N-1:0]  out1,
  output logic [N-1:0]  out2,
  output logic [N-1:0]  out3,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [1:0]    dst_q, dst_d;
  logic [1:0]    rr_q, rr_d;
  logic [N-1:0]  hold_q, hold_d;
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  logic          in_fire;
  logic          out_fire;
  logic [N-1:0]  demux_in;

  assign out_fire = (state_q == FULL) && out_ready[dst_q];
  assign in_ready = (state_q == EMPTY) || out_fire;
  assign in_fire  = in_valid && in_ready;
  assign busy     = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    for (int unsigned k = 0; k < NCH; k++) cnt_d[k] = cnt_q[k];

    if (out_fire) cnt_d[dst_q] = cnt_q[dst_q] + CW'(1);

    if (in_fire) begin
      state_d = FULL;
      hold_d  = in_data;
      if (mode == MODE_DIR) begin
        dst_d = in_dest;
      end else begin
        dst_d = rr_q;
        rr_d  = rr_q + 2'd1;
      end
    end else if (out_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      dst_q   <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      for (int unsigned k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      for (int unsigned k = 0; k < NCH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    out_valid = '0;
    if (state_q == FULL) out_valid[dst_q] = 1'b1;
  end

  // A drained word stays in hold_q; gating here keeps every channel at zero while EMPTY.
  assign demux_in = (state_q == FULL) ? hold_q : '0;

  demux_1_4_n_bit #(
    .N(N)
  ) u_demux (
    .s0  (dst_q[0]),
    .s1  (dst_q[1]),
    .i0  (demux_in),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3)
  );

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule
